// File: rtl/mult_rr_n_to_1.sv
// N-channel round-robin arbiter feeding a single-entry registered output stage.
// Define MULT_RR_LOCK_EN to add the lock_in port and channel-locking logic.
module mult_rr_n_to_1 #(
    parameter int width     = 16,
    parameter int channels  = 4,
    parameter int sel_width = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [channels-1:0]       req_valid,
    input  logic [channels*width-1:0] req_data,
    output logic [channels-1:0]       req_ready,
    output logic                      out_valid,
    output logic [width-1:0]          out_data,
    output logic [sel_width-1:0]      out_sel,
    input  logic                      out_ready
`ifdef MULT_RR_LOCK_EN
    ,
    input  logic [channels-1:0]       lock_in
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                  state, state_next;
    logic [sel_width-1:0]    ptr, ptr_next, grant;
    logic [2*channels-1:0]   rot;
    logic [width-1:0]        grant_data;
    logic                    found, load_en, xfer;
    int                      idx;

`ifdef MULT_RR_LOCK_EN
    logic                    lock_flag, lock_req;
    logic [sel_width-1:0]    lock_owner;

    assign lock_req = |(lock_in & req_valid & req_ready);
`endif

    assign out_valid = (state == FULL);
    assign load_en   = !out_valid || out_ready;
    assign xfer      = |(req_valid & req_ready);
    assign ptr_next  = (int'(grant) == channels - 1) ? '0 : grant + 1'b1;

    // Doubling the valid vector turns the wrap-around search into a linear scan from ptr.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        grant = '0;
        found = 1'b0;
        idx   = 0;
        rot   = {req_valid, req_valid} >> ptr;
        for (int i = 0; i < channels; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                idx   = int'(ptr) + i;
                if (idx >= channels) idx = idx - channels;
                grant = sel_width'(idx);
            end
        end
`ifdef MULT_RR_LOCK_EN
        if (lock_flag) begin
            grant = lock_owner;
            found = |(req_valid & (channels'(1) << lock_owner));
        end
`endif
    end

    always_comb begin
        grant_data = '0;
        req_ready  = '0;
        for (int k = 0; k < channels; k++) begin
            if (sel_width'(k) == grant) begin
                grant_data   = req_data[k*width +: width];
                req_ready[k] = found && load_en && rst_n;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (xfer) state_next = FULL;
            FULL:    if (out_ready && !xfer) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_data <= '0;
            out_sel  <= '0;
            ptr      <= '0;
`ifdef MULT_RR_LOCK_EN
            lock_flag  <= 1'b0;
            lock_owner <= '0;
`endif
        end else begin
            state <= state_next;
            if (xfer) begin
                out_data <= grant_data;
                out_sel  <= grant;
`ifdef MULT_RR_LOCK_EN
                lock_flag  <= lock_req;
                lock_owner <= grant;
                if (!lock_req) ptr <= ptr_next;
`else
                ptr <= ptr_next;
`endif
            end
        end
    end

endmodule
